// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_arb_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam byte_t DEFAULT_LASTCHAR = 8'h0A;

  // (base + off) mod n, for base < n and off < n.
  function automatic int unsigned rr_wrap(input int unsigned base,
                                          input int unsigned off,
                                          input int unsigned n);
    int unsigned s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at ptr, ptr+1, ... (wrapping).
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (req[IW'(rr_wrap(32'(ptr), 32'(k), N))]) begin
        gnt_idx   = IW'(rr_wrap(32'(ptr), 32'(k), N));
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Line-atomic round-robin sharing of one UART transmit byte port, with lock timeout.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter bit          LINE_LOCK    = 1'b1,
  parameter byte_t       LASTCHAR     = DEFAULT_LASTCHAR,
  parameter int unsigned LOCK_TIMEOUT = 1024,
  localparam int unsigned OW = $clog2(NUM_REQ)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [NUM_REQ-1:0][7:0] req_data_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  output logic                    tx_valid_o,
  output logic [7:0]              tx_data_o,
  input  logic                    tx_ready_i,
  output logic                    lock_active_o,
  output logic [OW-1:0]           owner_o,
  output logic                    timeout_o
);

  localparam int unsigned   CW       = $clog2(LOCK_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_TIMEOUT - 1);

  arb_state_e    r_state, w_state_nxt;
  logic [OW-1:0] r_owner, w_owner_nxt;
  logic [OW-1:0] r_ptr, w_ptr_nxt;
  logic [CW-1:0] r_idle_cnt, w_idle_cnt_nxt;
  logic          r_timeout, w_timeout_nxt;
  logic          r_tx_valid;
  byte_t         r_tx_data;

  logic [OW-1:0] w_gnt_idx;
  logic          w_gnt_valid;
  logic [OW-1:0] w_owner_inc;
  logic          w_slot_free;
  logic          w_owner_valid;
  byte_t         w_owner_data;
  logic          w_accept;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req       (req_valid_i),
    .ptr       (r_ptr),
    .gnt_idx   (w_gnt_idx),
    .gnt_valid (w_gnt_valid)
  );

  assign w_slot_free   = !r_tx_valid || tx_ready_i;
  assign w_owner_valid = req_valid_i[r_owner];
  assign w_owner_data  = req_data_i[r_owner];
  assign w_owner_inc   = OW'(rr_wrap(32'(r_owner), 32'd1, NUM_REQ));

  // Next-state: grant from IDLE, release on line end / per byte / timeout.
  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_ptr_nxt      = r_ptr;
    w_idle_cnt_nxt = r_idle_cnt;
    w_timeout_nxt  = 1'b0;
    w_accept       = 1'b0;
    req_ready_o    = '0;
    case (r_state)
      IDLE: begin
        if (w_gnt_valid) begin
          w_state_nxt    = LOCKED;
          w_owner_nxt    = w_gnt_idx;
          w_idle_cnt_nxt = '0;
        end
      end
      LOCKED: begin
        req_ready_o[r_owner] = w_slot_free;
        w_accept             = w_owner_valid && w_slot_free;
        if (w_accept) begin
          w_idle_cnt_nxt = '0;
          if (!LINE_LOCK || (w_owner_data == LASTCHAR)) begin
            w_state_nxt = IDLE;
            w_ptr_nxt   = w_owner_inc;
          end
        end else if (w_owner_valid) begin
          w_idle_cnt_nxt = '0;
        end else if (r_idle_cnt == CNT_LAST) begin
          w_state_nxt    = IDLE;
          w_ptr_nxt      = w_owner_inc;
          w_timeout_nxt  = 1'b1;
          w_idle_cnt_nxt = '0;
        end else begin
          w_idle_cnt_nxt = r_idle_cnt + CW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM, pointer, owner and idle counter registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_idle_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_ptr      <= w_ptr_nxt;
      r_idle_cnt <= w_idle_cnt_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  // One-entry output register toward the UART transmitter.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else if (w_accept) begin
      r_tx_valid <= 1'b1;
      r_tx_data  <= w_owner_data;
    end else if (tx_ready_i) begin
      r_tx_valid <= 1'b0;
    end
  end

  assign tx_valid_o    = r_tx_valid;
  assign tx_data_o     = r_tx_data;
  assign lock_active_o = (r_state == LOCKED);
  assign owner_o       = r_owner;
  assign timeout_o     = r_timeout;

endmodule
